// File: rtl/uart_tx_top_if.sv
// uart_tx_top_if: holding-register, line-control and serial-pin signals of the UART transmitter.
interface uart_tx_top_if;
    logic       baud_pulse;
    logic       pen;
    logic       thre;
    logic       stb;
    logic       stick_parity;
    logic       eps;
    logic       set_break;
    logic [7:0] din;
    logic [1:0] wls;
    logic       pop;
    logic       sreg_empty;
    logic       tx;
    modport master (
        output baud_pulse, pen, thre, stb, stick_parity, eps, set_break, din, wls,
        input  pop, sreg_empty, tx
    );
    modport slave (
        input  baud_pulse, pen, thre, stb, stick_parity, eps, set_break, din, wls,
        output pop, sreg_empty, tx
    );
endinterface

// File: rtl/uart_tx_top.sv
// uart_tx_top: 16550-style transmit serializer, 16x baud ticks per bit, 5-8 data bits, parity, 1/1.5/2 stop.
module uart_tx_top (
    input  logic          clk,
    input  logic          rst,
    uart_tx_top_if.slave  u
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t     r_state, w_state;
    logic [3:0] r_tick, w_tick;
    logic [2:0] r_cnt, w_cnt;
    logic [7:0] r_sreg, w_sreg;
    logic [1:0] r_wls;
    logic       r_pen, r_stb, r_par, r_pop, r_empty, r_tx;
    logic       w_load, w_empty, w_tx, w_par, w_stop_end;
    logic [7:0] w_mask;
    assign w_mask = 8'hFF >> (2'd3 - u.wls);
    assign w_par  = u.stick_parity ? ~u.eps : (u.eps ? ^(u.din & w_mask) : ~^(u.din & w_mask));
    // r_cnt selects the stop period: 0 = first 16 ticks, 1 = extra half or full period
    assign w_stop_end = (r_tick == ((r_cnt[0] && r_wls == 2'b00) ? 4'd7 : 4'd15)) && (r_cnt[0] || !r_stb);
    always_comb begin
        w_state = r_state;
        w_tick  = r_tick;
        w_cnt   = r_cnt;
        w_sreg  = r_sreg;
        w_load  = 1'b0;
        w_empty = r_empty;
        if (u.baud_pulse) begin
            w_tick = r_tick + 4'd1;
            case (r_state)
                S_IDLE: begin
                    w_tick = 4'd0;
                    w_load = !u.thre;
                end
                S_START: if (r_tick == 4'd15) begin
                    w_state = S_DATA;
                    w_cnt   = 3'd0;
                end
                S_DATA: if (r_tick == 4'd15) begin
                    w_sreg = r_sreg >> 1;
                    w_cnt  = r_cnt + 3'd1;
                    if (r_cnt == {1'b0, r_wls} + 3'd4) begin
                        w_state = r_pen ? S_PARITY : S_STOP;
                        w_cnt   = 3'd0;
                    end
                end
                S_PARITY: if (r_tick == 4'd15) begin
                    w_state = S_STOP;
                    w_cnt   = 3'd0;
                end
                S_STOP: if (w_stop_end) begin
                    w_state = S_IDLE;
                    w_load  = !u.thre;
                    w_empty = u.thre;
                end else if (r_tick == 4'd15) begin
                    w_cnt = 3'd1;
                end
                default: w_state = S_IDLE;
            endcase
            if (w_load) begin
                w_state = S_START;
                w_tick  = 4'd0;
                w_sreg  = u.din;
                w_empty = 1'b0;
            end
        end
        w_tx = u.set_break ? 1'b0 :
               (w_state == S_START)  ? 1'b0 :
               (w_state == S_DATA)   ? w_sreg[0] :
               (w_state == S_PARITY) ? r_par : 1'b1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_tick  <= 4'd0;
            r_cnt   <= 3'd0;
            r_sreg  <= 8'd0;
            r_wls   <= 2'd0;
            r_pen   <= 1'b0;
            r_stb   <= 1'b0;
            r_par   <= 1'b0;
            r_pop   <= 1'b0;
            r_empty <= 1'b1;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_tick  <= w_tick;
            r_cnt   <= w_cnt;
            r_sreg  <= w_sreg;
            r_pop   <= w_load;
            r_empty <= w_empty;
            r_tx    <= w_tx;
            if (w_load) begin
                r_wls <= u.wls;
                r_pen <= u.pen;
                r_stb <= u.stb;
                r_par <= w_par;
            end
        end
    end
    assign u.pop        = r_pop;
    assign u.sreg_empty = r_empty;
    assign u.tx         = r_tx;
endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top: scoreboard bench; the driver queues expected frames, a monitor decodes tx per baud tick.
module tb_uart_tx_top;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_top_if ifc ();
    uart_tx_top dut (.clk(clk), .rst(rst), .u(ifc));

    typedef struct {
        logic [7:0] d;
        int         n;
        bit         pe;
        bit         pv;
        int         stop;
    } frame_t;

    frame_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_pops = 0;
    int div = 6;
    int bcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic frame_t model(input logic [7:0] d, input logic [1:0] w,
                                     input bit pen, input bit eps, input bit st, input bit stb);
        frame_t f;
        int ones = 0;
        f.d = d;
        f.n = 5 + int'(w);
        for (int i = 0; i < f.n; i++) ones += int'(d[i]);
        f.pe = pen;
        f.pv = st ? !eps : (eps ? (ones % 2 == 1) : (ones % 2 == 0));
        f.stop = !stb ? 16 : (w == 2'b00 ? 24 : 32);
        return f;
    endfunction

    function automatic int frame_len(input frame_t f);
        return 16 * (1 + f.n + int'(f.pe)) + f.stop;
    endfunction

    function automatic bit exp_bit(input frame_t f, input int t);
        int idx = t / 16;
        if (idx == 0) return 1'b0;
        if (idx <= f.n) return f.d[idx-1];
        if (f.pe && idx == f.n + 1) return f.pv;
        return 1'b1;
    endfunction

    initial begin
        ifc.baud_pulse = 1'b0;
        forever begin
            @(negedge clk);
            bcnt++;
            if (bcnt >= div) begin
                bcnt = 0;
                ifc.baud_pulse = 1'b1;
            end else begin
                ifc.baud_pulse = 1'b0;
            end
        end
    end

    initial begin : monitor
        frame_t f;
        int t;
        bit in_f, bp, brk, thr;
        t = 0;
        in_f = 1'b0;
        forever begin
            @(posedge clk);
            bp  = ifc.baud_pulse;
            brk = ifc.set_break;
            thr = ifc.thre;
            #1;
            if (!rst) begin
                in_f = 1'b0;
                continue;
            end
            if (in_f && bp) begin
                t++;
                if (t == frame_len(f)) begin
                    in_f = 1'b0;
                    if (!thr) check("b2b_pop", ifc.pop, 1'b1);
                    else check("end_empty", ifc.sreg_empty, 1'b1);
                end
            end
            if (ifc.pop) begin
                n_pops++;
                check("pop_in_frame", in_f, 1'b0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: pop seen with no character offered at %0t", $time);
                end else begin
                    f = exp_q.pop_front();
                    in_f = 1'b1;
                    t = 0;
                end
            end
            if (bp) begin
                if (in_f) begin
                    check("tx_bit", ifc.tx, brk ? 1'b0 : exp_bit(f, t));
                    check("empty_busy", ifc.sreg_empty, 1'b0);
                end else begin
                    check("tx_idle", ifc.tx, !brk);
                    check("empty_idle", ifc.sreg_empty, 1'b1);
                end
            end
        end
    end

    task automatic offer(input logic [7:0] d, input logic [1:0] w,
                         input bit pen, input bit eps, input bit st, input bit stb);
        bit got;
        got = 1'b0;
        @(negedge clk);
        ifc.din = d;
        ifc.wls = w;
        ifc.pen = pen;
        ifc.eps = eps;
        ifc.stick_parity = st;
        ifc.stb = stb;
        ifc.thre = 1'b0;
        exp_q.push_back(model(d, w, pen, eps, st, stb));
        for (int i = 0; i < 5000 && !got; i++) begin
            @(posedge clk);
            #1;
            got = ifc.pop;
        end
        check("pop_wait", got, 1'b1);
    endtask

    // holding register drained; scramble the format inputs to prove they are latched per frame
    task automatic release_fifo();
        @(negedge clk);
        ifc.thre = 1'b1;
        ifc.din = 8'($urandom);
        ifc.wls = 2'($urandom);
        ifc.pen = 1'($urandom);
        ifc.eps = 1'($urandom);
        ifc.stick_parity = 1'($urandom);
        ifc.stb = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            ok = ifc.sreg_empty && exp_q.size() == 0;
        end
        check("idle_wait", ok, 1'b1);
    endtask

    initial begin
        int p0;
        ifc.thre = 1'b0;
        ifc.din = 8'h5A;
        ifc.wls = 2'b11;
        ifc.pen = 1'b1;
        ifc.eps = 1'b0;
        ifc.stick_parity = 1'b0;
        ifc.stb = 1'b0;
        ifc.set_break = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifc.din = 8'($urandom);
            check("rst_tx", ifc.tx, 1'b1);
            check("rst_pop", ifc.pop, 1'b0);
            check("rst_empty", ifc.sreg_empty, 1'b1);
        end
        ifc.thre = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        offer(8'h13, 2'b11, 1, 1, 0, 1); release_fifo(); wait_idle();
        offer(8'h1F, 2'b00, 1, 0, 0, 1); release_fifo(); wait_idle();
        offer(8'h6C, 2'b11, 1, 1, 1, 0); release_fifo(); wait_idle();
        offer(8'h6C, 2'b10, 1, 0, 1, 0); release_fifo(); wait_idle();
        offer(8'hC3, 2'b01, 0, 0, 0, 0); release_fifo(); wait_idle();

        p0 = n_pops;
        offer(8'hA5, 2'b11, 0, 0, 0, 0);
        offer(8'h3C, 2'b11, 0, 0, 0, 0);
        release_fifo();
        wait_idle();
        check("b2b_pop_count", n_pops - p0, 2);

        offer(8'hF0, 2'b11, 1, 1, 0, 1);
        release_fifo();
        repeat (16 * 6 * 3 + 10) @(negedge clk);
        ifc.set_break = 1'b1;
        @(posedge clk);
        #1;
        check("break_tx", ifc.tx, 1'b0);
        check("break_empty", ifc.sreg_empty, 1'b0);
        repeat (200) @(negedge clk);
        ifc.set_break = 1'b0;
        wait_idle();

        offer(8'h81, 2'b11, 1, 0, 0, 1);
        release_fifo();
        repeat (16 * 6 * 4 + 7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_tx", ifc.tx, 1'b1);
        check("midrst_empty", ifc.sreg_empty, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        div = $urandom_range(2, 6);
        for (int k = 0; k < 20; k++) begin
            offer(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                release_fifo();
                if ($urandom_range(0, 1) == 1) wait_idle();
            end
        end
        release_fifo();
        wait_idle();
        check("exp_q_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_top.md
Name: uart_tx_top

Overview:
16550-compatible UART transmit serializer. It sits between the TX holding register/FIFO and the serial pin. It pulls one character per frame from the holding register and shifts out start, 5–8 data bits (LSB first), optional parity and 1/1.5/2 stop bits. Bit timing is paced by a 16x oversampled baud tick from the baud generator.

Parameters:
none (all frame format comes from LCR-style input ports)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
baud_pulse  input  1  one-clk-wide 16x baud tick; FSM and tick counter advance only on clk edges where baud_pulse=1
pen  input  1  parity enable (LCR[3])
thre  input  1  holding register empty; 0 means a character is waiting on din
stb  input  1  stop bit select (LCR[2]): 0 gives 1 stop bit; 1 gives 2 stop bits, or 1.5 stop bits when wls=00
stick_parity  input  1  stick parity (LCR[5])
eps  input  1  even parity select (LCR[4]): 1 = even, 0 = odd
set_break  input  1  break control (LCR[6]); forces tx low
din  input  8  character from holding register/FIFO head
wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits
pop  output  1  one-clk pulse: character on din consumed
sreg_empty  output  1  1 when shift register idle (LSR TEMT contribution)
tx  output  1  serial output; idle high

Behaviour:
- Reset (rst=0, async): state IDLE, tx=1, pop=0, sreg_empty=1, tick counter=0, shift register cleared. Reset mid-frame aborts the frame immediately.
- States: IDLE, START, DATA, PARITY, STOP. One bit period = 16 baud_pulses, counted by a 4-bit tick counter.
- IDLE:
  - tx=1, sreg_empty=1.
  - On a clk edge with baud_pulse=1 and thre=0: load din into the shift register; latch wls, pen, eps, stick_parity, stb for the frame; pop=1 for exactly that one clk cycle; sreg_empty<=0; tx<=0; go to START with tick counter=0.
  - If thre=1, stay in IDLE.
- START: tx=0 for 16 ticks, then go to DATA.
- DATA:
  - tx = shift register bit 0 for 16 ticks per bit, then shift right.
  - After 5+wls bits: go to PARITY if latched pen=1, else go to STOP.
- PARITY bit, computed over the 5+wls valid bits only:
  - stick_parity=1: bit = ~eps.
  - stick_parity=0, eps=1: bit = XOR of data (even parity).
  - stick_parity=0, eps=0: bit = ~XOR of data (odd parity).
  - Held for 16 ticks, then go to STOP.
- STOP:
  - tx=1. Duration: 16 ticks if stb=0; 24 ticks if stb=1 and wls=00; 32 ticks if stb=1 and wls≠00.
  - On the final stop tick with thre=0: load the next character back-to-back (pop pulse, tx<=0, go to START) with no idle gap.
  - Otherwise go to IDLE with sreg_empty<=1.
- set_break=1: tx forced to 0 in every state; the FSM, pop and sreg_empty are unaffected. Releasing set_break restores normal tx on the next clk.
- Input changes mid-frame: changes to din/format inputs have no effect until the next load. thre is sampled only at load points.
- pop never asserts twice for one character and never asserts while sreg_empty=0, except at the back-to-back load edge.
- tx is registered, so it is glitch-free.

Test Plan:
- Reset: hold rst=0 for 5 clks with traffic on the inputs -> tx=1, pop=0, sreg_empty=1 throughout.
- 8E2 frame: baud_pulse every 6th clk; din=0x13, wls=11, pen=1, eps=1, stick=0, stb=1, thre=0 -> single pop; tx sequence 0,1,1,0,0,1,0,0,0, parity 1, stop 1,1; each bit 16 ticks (96 clks); sreg_empty low for 192 ticks.
- 5-bit framing: din=0x1F, wls=00, pen=1, eps=0, stb=1 -> 5 data bits all 1, odd parity 0, stop held exactly 24 ticks; din[7:5] never transmitted.
- Stick parity and 1 stop bit: stick_parity=1 with eps=1 -> parity bit 0; with eps=0 -> parity bit 1. pen=0 -> no parity bit; stb=0 -> 16-tick stop.
- Back-to-back: thre held 0 for two characters 0xA5 then 0x3C -> second start bit begins immediately after the last stop tick; exactly two pop pulses; sreg_empty stays 0 between frames.
- Break and mid-frame reset: set_break=1 mid-data -> tx=0 while the frame timing continues. rst=0 mid-frame -> tx=1 and sreg_empty=1 immediately.
